// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding, flag bit
// positions, divider state encoding and opcode classification helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SBC  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_NOT  = 4'd11,
    OP_CMP  = 4'd12,
    OP_INC  = 4'd13,
    OP_DEC  = 4'd14,
    OP_PASS = 4'd15
  } alu_op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 3;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  // Ops whose V flag reports signed overflow of an add or subtract.
  function automatic logic is_addsub(input alu_op_e op);
    return op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP, OP_INC, OP_DEC};
  endfunction

  // Ops routed to the multi-cycle divider instead of the single-cycle path.
  function automatic logic is_div(input alu_op_e op);
    return op == OP_DIV;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider producing one quotient bit per clock.
// The first quotient bit is resolved on the start edge, so the quotient is
// ready WIDTH-1 edges later and is held in DIV_DONE until acknowledged.
// Division by zero naturally yields an all-ones quotient.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The wrapped low-bit subtraction is
  // exact whenever the trial fits, because the true difference is < divisor.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;
    shifted = {r, q[WIDTH-1]};
    q_bit   = (shifted >= {1'b0, d});
    r_next  = q_bit ? (shifted[WIDTH-1:0] - d) : shifted[WIDTH-1:0];
    return {r_next, q[WIDTH-2:0], q_bit};
  endfunction

  // Divider sequencer: load and first step on start, iterate, then park the
  // quotient until the output stage takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            {rem, quo} <= div_step('0, dividend, divisor);
            dvsr       <= divisor;
            cnt        <= CW'(WIDTH - 1);
            state      <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          {rem, quo} <= div_step(rem, quo, dvsr);
          cnt        <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ack) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign busy     = (state != DIV_IDLE);
  assign done     = (state == DIV_DONE);
  assign quotient = quo;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle datapath for all ops except DIV, which runs
// on alu_divider. Results leave through one registered valid/ready slot.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int OPCODE      = 4,
  parameter int REGS_CODING = 3,
  parameter int FLAGS       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE-1:0]      opcode,
  input  logic [WIDTH-1:0]       op1,
  input  logic [WIDTH-1:0]       op2,
  input  logic                   cin,
  input  logic [REGS_CODING-1:0] dest_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic [FLAGS-1:0]       flags,
  output logic [REGS_CODING-1:0] dest_out,
  output logic                   wr_en
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  alu_op_e                op_e;
  logic                   slot_free;
  logic                   accept;
  logic                   start_div;
  logic                   div_busy;
  logic                   div_done;
  logic                   div_ack;
  logic [WIDTH-1:0]       div_quo;
  logic [REGS_CODING-1:0] div_dest;
  logic                   div_zero;
  logic [WIDTH-1:0]       div_res;
  logic [FLAGS-1:0]       div_flags;

  logic [WIDTH:0]         wide;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH:0]         cin_x;
  logic                   shift_big;
  logic [WIDTH-1:0]       sc_res;
  logic                   sc_carry;
  logic                   sc_ovf;
  logic                   sc_wr;
  logic [FLAGS-1:0]       sc_flags;

  function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, b, r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign op_e      = alu_op_e'(opcode);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !div_busy && slot_free;
  assign accept    = in_valid && in_ready;
  assign start_div = accept && is_div(op_e);
  assign div_ack   = div_done && slot_free;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_div),
    .dividend (op1),
    .divisor  (op2),
    .ack      (div_ack),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Single-cycle datapath; add/sub work at WIDTH+1 bits so the top bit is carry/borrow.
  always_comb begin
    wide      = '0;
    cin_x     = {{WIDTH{1'b0}}, cin};
    prod      = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};
    shift_big = |op2[WIDTH-1:SHW];
    sc_res    = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    sc_wr     = 1'b1;
    case (op_e)
      OP_ADD: begin
        wide   = {1'b0, op1} + {1'b0, op2};
        sc_res = wide[WIDTH-1:0];
        sc_ovf = add_ovf(op1, op2, sc_res);
      end
      OP_ADC: begin
        wide   = {1'b0, op1} + {1'b0, op2} + cin_x;
        sc_res = wide[WIDTH-1:0];
        sc_ovf = add_ovf(op1, op2, sc_res);
      end
      OP_SUB, OP_CMP: begin
        wide   = {1'b0, op1} - {1'b0, op2};
        sc_res = wide[WIDTH-1:0];
        sc_ovf = sub_ovf(op1, op2, sc_res);
        sc_wr  = (op_e != OP_CMP);
      end
      OP_SBC: begin
        wide   = {1'b0, op1} - {1'b0, op2} - cin_x;
        sc_res = wide[WIDTH-1:0];
        sc_ovf = sub_ovf(op1, op2, sc_res);
      end
      OP_INC: begin
        wide   = {1'b0, op1} + ONE_X;
        sc_res = wide[WIDTH-1:0];
        sc_ovf = add_ovf(op1, ONE_W, sc_res);
      end
      OP_DEC: begin
        wide   = {1'b0, op1} - ONE_X;
        sc_res = wide[WIDTH-1:0];
        sc_ovf = sub_ovf(op1, ONE_W, sc_res);
      end
      OP_MUL: begin
        sc_res   = prod[WIDTH-1:0];
        sc_carry = |prod[2*WIDTH-1:WIDTH];
      end
      OP_AND:  sc_res = op1 & op2;
      OP_OR:   sc_res = op1 | op2;
      OP_XOR:  sc_res = op1 ^ op2;
      OP_NOT:  sc_res = ~op1;
      OP_PASS: sc_res = op1;
      OP_SHL:  sc_res = shift_big ? '0 : (op1 << op2[SHW-1:0]);
      OP_SHR:  sc_res = shift_big ? '0 : (op1 >> op2[SHW-1:0]);
      default: sc_res = '0;
    endcase
    if (is_addsub(op_e)) sc_carry = wide[WIDTH];
    sc_flags         = '0;
    sc_flags[FLAG_C] = sc_carry;
    sc_flags[FLAG_S] = sc_res[WIDTH-1];
    sc_flags[FLAG_V] = sc_ovf;
    sc_flags[FLAG_Z] = (sc_res == '0);
  end

  // Divider result and flags; a zero divisor forces all ones with carry set.
  always_comb begin
    div_res           = div_zero ? '1 : div_quo;
    div_flags         = '0;
    div_flags[FLAG_C] = div_zero;
    div_flags[FLAG_S] = div_res[WIDTH-1];
    div_flags[FLAG_Z] = (div_res == '0);
  end

  // Remember the tag and zero-divisor condition of the DIV in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_dest <= '0;
      div_zero <= 1'b0;
    end else if (start_div) begin
      div_dest <= dest_in;
      div_zero <= (op2 == '0);
    end
  end

  // Output slot: load a single-cycle result or a finished quotient, else drain on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      dest_out  <= '0;
      wr_en     <= 1'b0;
    end else if (accept && !is_div(op_e)) begin
      out_valid <= 1'b1;
      result    <= sc_res;
      flags     <= sc_flags;
      dest_out  <= dest_in;
      wr_en     <= sc_wr;
    end else if (div_ack) begin
      out_valid <= 1'b1;
      result    <= div_res;
      flags     <= div_flags;
      dest_out  <= div_dest;
      wr_en     <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_alu_pipe;

  localparam int WIDTH       = 32;
  localparam int OPCODE      = 4;
  localparam int REGS_CODING = 3;
  localparam int FLAGS       = 4;

  localparam logic [3:0] T_ADD = 4'd0,  T_ADC = 4'd1,  T_SUB = 4'd2,  T_SBC = 4'd3;
  localparam logic [3:0] T_MUL = 4'd4,  T_DIV = 4'd5,  T_AND = 4'd6,  T_OR  = 4'd7;
  localparam logic [3:0] T_XOR = 4'd8,  T_SHL = 4'd9,  T_SHR = 4'd10, T_NOT = 4'd11;
  localparam logic [3:0] T_CMP = 4'd12, T_INC = 4'd13, T_DEC = 4'd14, T_PASS = 4'd15;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [OPCODE-1:0]      opcode;
  logic [WIDTH-1:0]       op1;
  logic [WIDTH-1:0]       op2;
  logic                   cin;
  logic [REGS_CODING-1:0] dest_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       result;
  logic [FLAGS-1:0]       flags;
  logic [REGS_CODING-1:0] dest_out;
  logic                   wr_en;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic        wr;
    logic [2:0]  dest;
  } exp_t;

  exp_t        sb_q[$];
  int          assertions;
  int          failures;
  logic        obs_valid;
  logic        obs_ready;
  logic [31:0] obs_result;
  logic [31:0] last_res;
  logic [3:0]  last_flags;
  logic        last_wr;

  alu_pipe #(
    .WIDTH(WIDTH), .OPCODE(OPCODE), .REGS_CODING(REGS_CODING), .FLAGS(FLAGS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op1(op1), .op2(op2), .cin(cin), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flags(flags), .dest_out(dest_out), .wr_en(wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic and signed range checks.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, b,
                                 input logic c, input logic [2:0] d);
    exp_t e;
    longint unsigned ua, ub, full;
    longint sa, sb, ci, st;
    bit signed_op, carry;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    ci = c ? 1 : 0;
    full = 0; st = 0; signed_op = 0; carry = 0;
    e.wr = 1'b1; e.dest = d; e.res = '0;
    case (op)
      T_ADD: begin full = ua + ub;  carry = (full > 64'hFFFF_FFFF); st = sa + sb; signed_op = 1; end
      T_ADC: begin full = ua + ub + ci; carry = (full > 64'hFFFF_FFFF); st = sa + sb + ci; signed_op = 1; end
      T_SUB: begin full = ua - ub;  carry = (ua < ub); st = sa - sb; signed_op = 1; end
      T_CMP: begin full = ua - ub;  carry = (ua < ub); st = sa - sb; signed_op = 1; e.wr = 1'b0; end
      T_SBC: begin full = ua - ub - ci; carry = (ua < ub + ci); st = sa - sb - ci; signed_op = 1; end
      T_INC: begin full = ua + 1;   carry = (full > 64'hFFFF_FFFF); st = sa + 1; signed_op = 1; end
      T_DEC: begin full = ua - 1;   carry = (ua < 1); st = sa - 1; signed_op = 1; end
      T_MUL: begin full = ua * ub;  carry = ((full >> 32) != 0); end
      T_DIV: begin
        if (ub == 0) begin full = 64'hFFFF_FFFF; carry = 1; end
        else full = ua / ub;
      end
      T_AND:  full = ua & ub;
      T_OR:   full = ua | ub;
      T_XOR:  full = ua ^ ub;
      T_NOT:  full = ~ua;
      T_PASS: full = ua;
      T_SHL:  full = (ub >= 32) ? 0 : (ua << ub);
      T_SHR:  full = (ub >= 32) ? 0 : (ua >> ub);
      default: full = 0;
    endcase
    e.res    = full[31:0];
    e.flg[0] = carry;
    e.flg[1] = e.res[31];
    e.flg[2] = signed_op && (st > 64'sd2147483647 || st < -64'sd2147483648);
    e.flg[3] = (e.res == 32'd0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle from a negedge, score any output handshake, then advance.
  task automatic applyStimulus(input bit iv, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit c, input logic [2:0] d,
                               input bit ordy, output bit acc);
    exp_t e;
    in_valid = iv; opcode = op; op1 = a; op2 = b; cin = c; dest_in = d; out_ready = ordy;
    #1;
    obs_valid  = out_valid;
    obs_ready  = in_ready;
    obs_result = result;
    acc        = iv && in_ready;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("spurious_out", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        checkOutput("result", 64'(result), 64'(e.res));
        checkOutput("flags", 64'(flags), 64'(e.flg));
        checkOutput("dest", 64'(dest_out), 64'(e.dest));
        checkOutput("wr_en", 64'(wr_en), 64'(e.wr));
        last_res = result; last_flags = flags; last_wr = wr_en;
      end
    end
    if (acc) sb_q.push_back(model(op, a, b, c, d));
    @(negedge clk);
  endtask

  // Issue one op, wait for its result with out_ready high, check latency.
  task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit c, input logic [2:0] d,
                       input int exp_lat, input bit chk_busy);
    bit acc;
    int tries, lat, ready_hi;
    acc = 0; tries = 0;
    while (!acc && tries < 50) begin
      applyStimulus(1, op, a, b, c, d, 1, acc);
      tries++;
    end
    checkOutput({name, "_accept"}, 64'(acc), 64'(1));
    lat = 0; ready_hi = 0; obs_valid = 0;
    while (!obs_valid && lat < 200) begin
      applyStimulus(0, T_ADD, '0, '0, 0, '0, 1, acc);
      lat++;
      if (!obs_valid && obs_ready) ready_hi++;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    if (chk_busy) checkOutput({name, "_in_ready_low"}, 64'(ready_hi), 64'(0));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit          acc;
    logic [3:0]  op;
    logic [31:0] a, b;
    assertions = 0; failures = 0;
    rst_n = 1'b0; in_valid = 0; opcode = '0; op1 = '0; op2 = '0;
    cin = 0; dest_in = '0; out_ready = 0;
    last_res = '0; last_flags = '0; last_wr = 0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_result", 64'(result), 64'(0));
    checkOutput("reset_flags", 64'(flags), 64'(0));
    checkOutput("reset_dest", 64'(dest_out), 64'(0));
    checkOutput("reset_wr_en", 64'(wr_en), 64'(0));
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed cases");
    runOp("add_wrap", T_ADD, 32'hFFFF_FFFF, 32'd1, 0, 3'd1, 1, 0);
    checkOutput("add_wrap_res", 64'(last_res), 64'(0));
    checkOutput("add_wrap_flags", 64'(last_flags), 64'(4'b1001));

    runOp("sub_ovf", T_SUB, 32'h8000_0000, 32'd1, 0, 3'd2, 1, 0);
    checkOutput("sub_ovf_res", 64'(last_res), 64'(32'h7FFF_FFFF));
    checkOutput("sub_ovf_flags", 64'(last_flags), 64'(4'b0100));

    runOp("cmp", T_CMP, 32'd5, 32'd7, 0, 3'd3, 1, 0);
    checkOutput("cmp_wr_en", 64'(last_wr), 64'(0));
    checkOutput("cmp_flags", 64'(last_flags), 64'(4'b0011));

    runOp("div", T_DIV, 32'd100, 32'd7, 0, 3'd4, WIDTH + 1, 1);
    checkOutput("div_res", 64'(last_res), 64'(14));

    runOp("div0", T_DIV, 32'd9, 32'd0, 0, 3'd5, WIDTH + 1, 1);
    checkOutput("div0_res", 64'(last_res), 64'(32'hFFFF_FFFF));
    checkOutput("div0_flags", 64'(last_flags), 64'(4'b0011));

    runOp("shl31", T_SHL, 32'd1, 32'd31, 0, 3'd6, 1, 0);
    checkOutput("shl31_res", 64'(last_res), 64'(32'h8000_0000));
    runOp("shl32", T_SHL, 32'd1, 32'd32, 0, 3'd7, 1, 0);
    checkOutput("shl32_res", 64'(last_res), 64'(0));
    checkOutput("shl32_flags", 64'(last_flags), 64'(4'b1000));
    runOp("mul_hi", T_MUL, 32'h0001_0000, 32'h0001_0000, 0, 3'd1, 1, 0);
    checkOutput("mul_hi_flags", 64'(last_flags), 64'(4'b1001));

    $display("[TB] output stall");
    applyStimulus(1, T_ADD, 32'd10, 32'd20, 0, 3'd1, 0, acc);
    checkOutput("stall_first_accept", 64'(acc), 64'(1));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, T_ADD, 32'd30, 32'd40, 0, 3'd2, 0, acc);
      checkOutput("stall_in_ready", 64'(obs_ready), 64'(0));
      checkOutput("stall_hold", 64'(obs_result), 64'(30));
    end
    applyStimulus(1, T_ADD, 32'd30, 32'd40, 0, 3'd2, 1, acc);
    checkOutput("stall_release_accept", 64'(acc), 64'(1));
    applyStimulus(0, T_ADD, '0, '0, 0, '0, 1, acc);
    checkOutput("stall_second_res", 64'(last_res), 64'(70));

    $display("[TB] reset during divide");
    runOp("pre_add", T_ADD, 32'h1234, 32'd1, 0, 3'd4, 1, 0);
    applyStimulus(1, T_DIV, 32'd1000, 32'd3, 0, 3'd5, 1, acc);
    checkOutput("mid_div_accept", 64'(acc), 64'(1));
    repeat (10) applyStimulus(0, T_ADD, '0, '0, 0, '0, 1, acc);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("mid_rst_result", 64'(result), 64'(0));
    checkOutput("mid_rst_flags", 64'(flags), 64'(0));
    checkOutput("mid_rst_dest", 64'(dest_out), 64'(0));
    checkOutput("mid_rst_wr_en", 64'(wr_en), 64'(0));
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'(1));
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 4) applyStimulus(0, T_ADD, '0, '0, 0, '0, 1, acc);
    runOp("post_rst_add", T_ADD, 32'd2, 32'd3, 0, 3'd6, 1, 0);
    checkOutput("post_rst_add_res", 64'(last_res), 64'(5));

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == T_DIV && $urandom_range(0, 3) != 0) op = T_ADC;
      a = rand_operand();
      b = rand_operand();
      if ((op == T_SHL || op == T_SHR) && $urandom_range(0, 1) == 1)
        b = 32'($urandom_range(0, 40));
      applyStimulus($urandom_range(0, 3) != 0, op, a, b, 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, acc);
    end
    for (int i = 0; i < 200 && sb_q.size() > 0; i++)
      applyStimulus(0, T_ADD, '0, '0, 0, '0, 1, acc);
    checkOutput("drain_empty", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
